// File: rtl/ttl_oc_bus_arbiter.sv
// ttl_oc_bus_arbiter: round-robin owner of one shared open-collector line with turnaround gap.
// Define TTL_ARB_TIMEOUT_EN to force release after MAX_HOLD grant cycles (tmo pulse).
module ttl_oc_bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int TURN_CYC = 1,
    parameter int MAX_HOLD = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] done_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [1:0]       owner_o,
    output logic             busy_o,
    output logic             turn_o,
    output logic             tmo_o
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] TURN  = 2'd2;

    if (N_REQ != 4 || TURN_CYC < 1 || TURN_CYC > 3 || MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_param
        $error("ttl_oc_bus_arbiter: illegal parameter value");
    end

    logic [1:0]       state_q, state_d, ptr_q, ptr_d, owner_q, owner_d, tcnt_q, tcnt_d;
    logic [1:0]       sel, idx;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             busy_q, busy_d, turn_q, turn_d, tmo_q, tmo_d;
    logic             found, norm_rel, to_hit;

`ifdef TTL_ARB_TIMEOUT_EN
    logic [3:0] hold_q, hold_d;
    assign hold_d = (state_q == GRANT) ? hold_q + 4'd1 : 4'd0;
    assign to_hit = (state_q == GRANT) && (hold_q == 4'(MAX_HOLD - 1));
    always_ff @(posedge clk) begin
        if (rst) hold_q <= 4'd0;
        else     hold_q <= hold_d;
    end
`else
    assign to_hit = 1'b0;
`endif

    // Scan downward so the last hit, nearest to ptr, wins.
    always_comb begin
        sel   = 2'd0;
        idx   = 2'd0;
        found = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (req_i[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    assign norm_rel = done_i[owner_q] | ~req_i[owner_q];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        turn_d  = turn_q;
        tcnt_d  = tcnt_q;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: if (found) begin
                state_d = GRANT;
                gnt_d   = N_REQ'(1) << sel;
                owner_d = sel;
                busy_d  = 1'b1;
            end
            GRANT: if (norm_rel | to_hit) begin
                state_d = TURN;
                gnt_d   = '0;
                busy_d  = 1'b0;
                turn_d  = 1'b1;
                tcnt_d  = 2'd0;
                ptr_d   = owner_q + 2'd1;
                tmo_d   = to_hit & ~norm_rel;
            end
            TURN: if (tcnt_q == 2'(TURN_CYC - 1)) begin
                state_d = IDLE;
                turn_d  = 1'b0;
            end else begin
                tcnt_d  = tcnt_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            turn_q  <= 1'b0;
            tcnt_q  <= 2'd0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            turn_q  <= turn_d;
            tcnt_q  <= tcnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign owner_o = owner_q;
    assign busy_o  = busy_q;
    assign turn_o  = turn_q;
    assign tmo_o   = tmo_q;
endmodule
